// File: rtl/cla_seq_adder_if.sv
// cla_seq_adder_if: request/result bundle for the nibble-serial adder.
// The requester drives start/sub/X/Y/Cin and the adder drives
// busy/done/S/Cout/V.
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output start, sub, X, Y, Cin,
    input  busy, done, S, Cout, V
  );

  modport slave (
    input  start, sub, X, Y, Cin,
    output busy, done, S, Cout, V
  );
endinterface

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder/subtractor that reuses a single 4-bit
// carry-lookahead slice, processing one nibble per clock, LSB nibble first.
// WIDTH must be a multiple of 4 and at least 8.
// Optional feature macro: CLA_SEQ_OVERFLOW_EN. When it is defined, V reports
// signed overflow. When it is undefined, V is tied to 0.

// 4-bit carry-lookahead slice (purely combinational).
module carry_lookahead_4bit (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s    = X & Y;
  assign p_s    = X ^ Y;
  assign c_s[0] = Cin;
  assign c_s[1] = g_s[0] | (p_s[0] & Cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & Cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & Cin);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & Cin);
  assign S      = p_s ^ c_s[3:0];
  assign Cout   = c_s[4];
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  cla_seq_adder_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             busy_s;
  logic             done_s;
  logic             last_s;

  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] s_r;
  logic [KW-1:0]    k_r;
  logic             c_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

  logic [KW+1:0]    bit_base_s;
  logic [3:0]       nib_a_s;
  logic [3:0]       nib_b_s;
  logic [3:0]       sum_s;
  logic             slice_cout_s;

  // The nibble index selects which 4-bit lane of the frozen operands feeds the slice.
  assign bit_base_s = {k_r, 2'b00};
  assign nib_a_s    = opa_r[bit_base_s +: 4];
  assign nib_b_s    = opb_r[bit_base_s +: 4];

  carry_lookahead_4bit u_slice (
    .X    (nib_a_s),
    .Y    (nib_b_s),
    .Cin  (c_r),
    .S    (sum_s),
    .Cout (slice_cout_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode together with the busy/done values for the coming cycle.
  always_comb begin
    state_s = state_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (k_r == K_LAST) begin
          last_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_RUN);
    done_s = (state_s == ST_DONE);
  end

  // Handshake outputs are registered so that they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Datapath: latch operands on an accepted start, then accumulate one nibble per RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r  <= {WIDTH{1'b0}};
      opb_r  <= {WIDTH{1'b0}};
      s_r    <= {WIDTH{1'b0}};
      k_r    <= {KW{1'b0}};
      c_r    <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            opa_r <= bus.X;
            opb_r <= bus.sub ? ~bus.Y : bus.Y;
            c_r   <= bus.sub ? 1'b1 : bus.Cin;
            k_r   <= {KW{1'b0}};
            s_r   <= {WIDTH{1'b0}};
          end
        end
        ST_RUN: begin
          s_r[bit_base_s +: 4] <= sum_s;
          c_r                  <= slice_cout_s;
          if (last_s) begin
            // Hold k at its final value so that it never wraps inside a transaction.
            cout_r <= slice_cout_s;
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CLA_SEQ_OVERFLOW_EN
  logic v_r;
  logic v_s;

  // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
  assign v_s = opa_r[WIDTH-1] ^ opb_r[WIDTH-1] ^ sum_s[3] ^ slice_cout_s;

  // Overflow flag is captured on the final RUN edge and held until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r <= 1'b0;
    end else if (state_r == ST_RUN && last_s) begin
      v_r <= v_s;
    end else begin
      v_r <= v_r;
    end
  end

  assign bus.V = v_r;
`else
  assign bus.V = 1'b0;
`endif

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.S    = s_r;
  assign bus.Cout = cout_r;
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: table-driven directed test of cla_seq_adder (WIDTH=16),
// plus hand-written sequences for ignored start, mid-run reset and
// back-to-back starts.
module tb_cla_seq_adder;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;
`ifdef CLA_SEQ_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive start for exactly one edge, then scramble the inputs; returns in the first busy cycle.
  task automatic drive_start(input logic [15:0] x, input logic [15:0] y,
                             input logic cin, input logic sub);
    @(negedge clk);
    bus.X     = x;
    bus.Y     = y;
    bus.Cin   = cin;
    bus.sub   = sub;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.X     = 16'($urandom);
    bus.Y     = 16'($urandom);
    bus.Cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  // Advance one negedge at a time until done, with a cycle budget.
  task automatic wait_done(input string nm, output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    while (bus.done !== 1'b1 && cyc < 50) begin
      if (bus.busy === 1'b1) bcyc++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) chk({nm, "_timeout"}, {31'd0, bus.done}, 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int   cyc;
    int   bcyc;
    logic seen;

    vecs[0] = '{"add_5555",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"add_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF};
    vecs[3] = '{"sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub_noborr",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF};
    vecs[6] = '{"add_cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[7] = '{"add_negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, OVF};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.X     = 16'h0000;
    bus.Y     = 16'h0000;
    bus.Cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_S",    {16'd0, bus.S},    32'd0);
    chk("rst_Cout", {31'd0, bus.Cout}, 32'd0);
    chk("rst_V",    {31'd0, bus.V},    32'd0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      drive_start(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub);
      wait_done(vecs[i].name, cyc, bcyc);
      chk({vecs[i].name, "_latency"}, cyc,  N);
      chk({vecs[i].name, "_busycyc"}, bcyc, N);
      chk({vecs[i].name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      chk({vecs[i].name, "_S"},    {16'd0, bus.S},    {16'd0, vecs[i].s});
      chk({vecs[i].name, "_Cout"}, {31'd0, bus.Cout}, {31'd0, vecs[i].cout});
      chk({vecs[i].name, "_V"},    {31'd0, bus.V},    {31'd0, vecs[i].v});
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      chk({vecs[i].name, "_S_hold"},     {16'd0, bus.S},    {16'd0, vecs[i].s});
    end

    // A second start during RUN is ignored.
    drive_start(16'hAAAA, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 16'h0F0F;
    bus.Y     = 16'h0F0F;
    bus.sub   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ign", cyc, bcyc);
    chk("ign_latency", cyc, 2);
    chk("ign_S",    {16'd0, bus.S},    32'h0000BBBB);
    chk("ign_Cout", {31'd0, bus.Cout}, 32'd0);
    @(negedge clk);
    chk("ign_busy_idle", {31'd0, bus.busy}, 32'd0);

    // Reset in the third busy cycle aborts the transaction.
    drive_start(16'hAAAA, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rstrun_partial_S", {16'd0, bus.S},    32'h000000BB);
    chk("rstrun_busy3",     {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstrun_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstrun_S",    {16'd0, bus.S},    32'd0);
    chk("rstrun_done", {31'd0, bus.done}, 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    chk("rstrun_no_done", {31'd0, seen}, 32'd0);
    drive_start(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_done("fresh", cyc, bcyc);
    chk("fresh_latency", cyc, N);
    chk("fresh_S", {16'd0, bus.S}, 32'h00000003);

    // Back-to-back: a start in the IDLE cycle right after done.
    @(negedge clk);
    drive_start(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done("b2b1", cyc, bcyc);
    chk("b2b1_S", {16'd0, bus.S}, 32'h00005555);
    @(negedge clk);
    chk("b2b_S_hold_idle", {16'd0, bus.S}, 32'h00005555);
    bus.X     = 16'h0F0F;
    bus.Y     = 16'h0101;
    bus.Cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_S_cleared", {16'd0, bus.S},    32'd0);
    chk("b2b_busy",      {31'd0, bus.busy}, 32'd1);
    wait_done("b2b2", cyc, bcyc);
    chk("b2b_done_spacing", 2 + cyc, N + 2);
    chk("b2b2_S", {16'd0, bus.S}, 32'h00001010);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle WIDTH-bit adder/subtractor that reuses one instance of the team's 4-bit carry-lookahead slice (`carry_lookahead_4bit`), one nibble per clock, LSB nibble first.
- A start/busy/done handshake sequences the slice.
- The block latches operands and registers the inter-nibble carry.
- It accumulates the result into a holding register.
- It sits between a register-file/ALU front end and any consumer that trades latency for area.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8; N = WIDTH/4 nibbles.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on a clk edge where state is IDLE.
- sub  input  1  sampled with start; 1 = X − Y, 0 = X + Y + Cin.
- X  input  WIDTH  operand A, sampled with start.
- Y  input  WIDTH  operand B, sampled with start.
- Cin  input  1  carry-in, sampled with start; ignored when sub=1.
- busy  output  1  high while nibbles are being processed (RUN).
- done  output  1  single-cycle pulse: result valid.
- S  output  WIDTH  result register.
- Cout  output  1  final carry out of the MSB nibble (sub: 1 = no borrow).
- V  output  1  signed overflow (see Configuration).

## Operation
- States are IDLE, RUN and DONE. Encoding is free; an unused state returns to IDLE.
- IDLE:
  - On start=1, latch X into opA and Y (sub ? ~Y : Y) into opB.
  - Set carry register c = (sub ? 1 : Cin).
  - Set nibble index k = 0 and clear S to 0.
  - Go to RUN.
- RUN:
  - The slice is driven with X = opA[4k+3:4k], Y = opB[4k+3:4k], Cin = c.
  - Each edge writes the slice sum into S[4k+3:4k], sets c to the slice Cout, and increments k.
  - When k = N−1 on an edge, also load Cout from the slice Cout and V, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing and no error flag.
- S, Cout and V hold their values from DONE until the next accepted start.
- k is ceil(log2 N) bits wide and never wraps within a transaction.
- Operands are frozen in opA/opB. X, Y, sub and Cin may change freely after the start edge.
- Subtraction is two's complement: X + ~Y + 1. Cout=0 means a borrow occurred.

## Timing
- Reset values: state IDLE, busy 0, done 0, S 0, Cout 0, V 0, k 0, c 0.
- Reset takes priority over start and aborts RUN/DONE on the next edge. Partial S is cleared and no done is produced.
- Start edge E0: state is RUN from E0 onward; busy=1 in the cycles after edges E0 … E(N−1).
- Nibble k is written on edge E(k+1).
- done=1 in the single cycle after edge EN; busy=0 in that cycle.
- Start-to-done latency is N edges (4 for WIDTH=16).
- Minimum spacing between accepted starts is N+2 edges (RUN ×N, DONE, IDLE).
- The slice is purely combinational. The critical path is the carry register → slice → S/c registers.

## Configuration
- CLA_SEQ_OVERFLOW_EN:
  - Defined: V is loaded on the last RUN edge with (carry into MSB bit) XOR (slice Cout). This is computed as opA[WIDTH−1] ^ opB[WIDTH−1] ^ sum[WIDTH−1] ^ Cout.
  - Undefined: V is tied to 0 and no overflow logic is synthesized.

## Test plan
- WIDTH=16, X=0x1234, Y=0x4321, Cin=0, sub=0:
  - busy high 4 cycles, then done pulse.
  - S=0x5555, Cout=0, V=0.
- X=0xFFFF, Y=0x0001, Cin=0, sub=0 → S=0x0000, Cout=1, V=0 (carry ripples across all 4 nibbles).
- X=0x7FFF, Y=0x0001, sub=0:
  - S=0x8000, Cout=0.
  - V=1 with CLA_SEQ_OVERFLOW_EN, V=0 without.
- X=0x0005, Y=0x0007, sub=1, Cin=1 (ignored) → S=0xFFFE, Cout=0. Then X=0x0007, Y=0x0005, sub=1 → S=0x0002, Cout=1.
- Start X=0xAAAA, Y=0x1111, then:
  - Pulse start again with new operands on the 2nd busy cycle. The second start is ignored and the result is S=0xBBBB.
  - Assert rst on the 3rd busy cycle. The next cycle shows busy=0, S=0, no done pulse.
  - A fresh start completes normally.
- Back-to-back: accept a new start in the IDLE cycle right after done. The previous S holds until that start edge, and the second done arrives N+2 edges after the first.
